// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: arbitrates per-core icache/dcache ports onto a single RAM port.
// Data requests beat instruction requests, cores are served round-robin, dcache grants lock for a block burst.
module mem_arbiter #(
    parameter int CPUS    = 2,
    parameter int BURST   = 2,
    parameter int IDLE_TO = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*32-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);
    localparam int         OW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] BURST_MAX  = 2'(BURST);
    localparam logic [1:0] IDLE_MAX   = 2'(IDLE_TO);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr;
    logic [1:0]      beats;
    logic [1:0]      idlecnt;

    logic [CPUS-1:0] dreq;
    logic [CPUS-1:0] cand;
    logic            found;
    logic [OW-1:0]   win;
    logic [OW-1:0]   win_next;
    logic            access;
    logic            own_dreq;
    logic [31:0]     own_daddr;
    logic [31:0]     own_dstore;
    logic [31:0]     own_iaddr;
    logic [1:0]      beats_inc;
    logic [1:0]      idle_inc;

    assign dreq       = dREN | dWEN;
    assign access     = (ramstate == RAM_ACCESS);
    assign own_dreq   = dreq[owner];
    assign own_daddr  = daddr[int'(owner)*32 +: 32];
    assign own_dstore = dstore[int'(owner)*32 +: 32];
    assign own_iaddr  = iaddr[int'(owner)*32 +: 32];
    assign beats_inc  = (beats == BURST_MAX) ? beats : beats + 2'd1;
    assign idle_inc   = (idlecnt == IDLE_MAX) ? idlecnt : idlecnt + 2'd1;
    assign win_next   = (win == OW'(CPUS - 1)) ? '0 : win + 1'b1;

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Any data request hides all instruction requests; the scan starts at rr and wraps.
    always_comb begin
        cand  = (|dreq) ? dreq : iREN;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < CPUS; i++) begin
            if (!found && cand[(int'(rr) + i) % CPUS]) begin
                found = 1'b1;
                win   = OW'((int'(rr) + i) % CPUS);
            end
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        case (state)
            GRANT_D: begin
                ramWEN       = dWEN[owner];
                ramREN       = dREN[owner] & ~dWEN[owner];
                ramaddr      = own_daddr;
                ramstore     = own_dstore;
                dwait[owner] = ~access;
            end
            GRANT_I: begin
                ramREN       = iREN[owner];
                ramaddr      = own_iaddr;
                iwait[owner] = ~access;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            owner   <= '0;
            rr      <= '0;
            beats   <= '0;
            idlecnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= (|dreq) ? GRANT_D : GRANT_I;
                        owner   <= win;
                        rr      <= win_next;
                        beats   <= '0;
                        idlecnt <= '0;
                    end
                end
                GRANT_D: begin
                    if (own_dreq) begin
                        idlecnt <= '0;
                        if (access) begin
                            if (beats_inc == BURST_MAX) begin
                                state <= IDLE;
                                beats <= '0;
                            end else begin
                                beats <= beats_inc;
                            end
                        end
                    end else begin
                        // A short gap between block words keeps the lock; a long one releases it.
                        if (idle_inc == IDLE_MAX) begin
                            state   <= IDLE;
                            beats   <= '0;
                            idlecnt <= '0;
                        end else begin
                            idlecnt <= idle_inc;
                        end
                    end
                end
                GRANT_I: begin
                    if (access || !iREN[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: scenarios queue the RAM beats they expect; a monitor pops and compares each completed beat.
module tb_mem_arbiter;
    localparam int         CPUS   = 2;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic               CLK = 1'b0;
    logic               nRST;
    logic [CPUS-1:0]    iREN, iwait, dREN, dWEN, dwait;
    logic [CPUS*32-1:0] iaddr, iload, daddr, dstore, dload;
    logic               ramREN, ramWEN;
    logic [31:0]        ramaddr, ramstore, ramload;
    logic [1:0]         ramstate;

    logic        ic_ren [CPUS];
    logic [31:0] ic_addr[CPUS];
    logic        dc_ren [CPUS];
    logic        dc_wen [CPUS];
    logic [31:0] dc_addr[CPUS];
    logic [31:0] dc_store[CPUS];

    assign iREN   = {ic_ren[1], ic_ren[0]};
    assign iaddr  = {ic_addr[1], ic_addr[0]};
    assign dREN   = {dc_ren[1], dc_ren[0]};
    assign dWEN   = {dc_wen[1], dc_wen[0]};
    assign daddr  = {dc_addr[1], dc_addr[0]};
    assign dstore = {dc_store[1], dc_store[0]};

    mem_arbiter #(.CPUS(CPUS), .BURST(2), .IDLE_TO(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) ramload <= $urandom();

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [1:0]  iw;
        logic [1:0]  dw;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_beat(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] store, input logic [1:0] iw, input logic [1:0] dw);
        beat_t e;
        e.ren = ren; e.wen = wen; e.addr = addr; e.store = store; e.iw = iw; e.dw = dw;
        sb.push_back(e);
    endtask

    task automatic expect_dburst(input int c, input logic wen, input logic [31:0] addr, input logic [31:0] data);
        for (int w = 0; w < 2; w++)
            expect_beat(~wen, wen, addr + 32'(4*w), data + 32'(w), 2'b11, ~(2'b01 << c));
    endtask

    task automatic drained(input string tag);
        repeat (2) tick();
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_low(input logic is_d, input int c);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((is_d ? dwait[c] : iwait[c]) && n < 60);
        check(is_d ? "dwait_grant" : "iwait_grant", 32'(is_d ? dwait[c] : iwait[c]), 32'd0);
    endtask

    task automatic dcache_burst(input int c, input logic wen, input logic [31:0] addr,
                                input logic [31:0] data, input int gap);
        for (int w = 0; w < 2; w++) begin
            dc_addr[c]  = addr + 32'(4*w);
            dc_store[c] = data + 32'(w);
            dc_wen[c]   = wen;
            dc_ren[c]   = ~wen;
            wait_low(1'b1, c);
            tick();
            if (w == 0 && gap > 0) begin
                dc_ren[c] = 1'b0;
                dc_wen[c] = 1'b0;
                repeat (gap) tick();
            end
        end
        dc_ren[c] = 1'b0;
        dc_wen[c] = 1'b0;
    endtask

    task automatic dcache_single(input int c, input logic [31:0] addr);
        dc_addr[c] = addr;
        dc_ren[c]  = 1'b1;
        wait_low(1'b1, c);
        tick();
        dc_ren[c]  = 1'b0;
    endtask

    task automatic icache_fetch(input int c, input logic [31:0] addr);
        ic_addr[c] = addr;
        ic_ren[c]  = 1'b1;
        wait_low(1'b0, c);
        tick();
        ic_ren[c]  = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1 && ramstate == ACCESS && (ramREN || ramWEN)) begin
            if (sb.size() == 0) begin
                check("beat_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("beat_ren", 32'(ramREN), 32'(mon_e.ren));
                check("beat_wen", 32'(ramWEN), 32'(mon_e.wen));
                check("beat_addr", ramaddr, mon_e.addr);
                if (mon_e.wen) check("beat_store", ramstore, mon_e.store);
                check("beat_iwait", 32'(iwait), 32'(mon_e.iw));
                check("beat_dwait", 32'(dwait), 32'(mon_e.dw));
                check("dload1", dload[63:32], ramload);
                check("iload0", iload[31:0], ramload);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        ramstate = ACCESS;
        for (int c = 0; c < CPUS; c++) begin
            ic_ren[c] = 1'b0; ic_addr[c] = '0;
            dc_ren[c] = 1'b0; dc_wen[c] = 1'b0; dc_addr[c] = '0; dc_store[c] = '0;
        end
        repeat (2) @(negedge CLK);
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iwait", 32'(iwait), 32'd3);
        check("rst_dwait", 32'(dwait), 32'd3);
        tick();
        nRST = 1'b1;
        tick();

        // 1: single dcache read, strobe one cycle after the request is seen
        expect_dburst(0, 1'b0, 32'h100, 32'h0);
        dc_ren[0] = 1'b1; dc_addr[0] = 32'h100;
        @(negedge CLK);
        check("s1_idle_ren", 32'(ramREN), 32'd0);
        tick();
        @(negedge CLK);
        check("s1_ren", 32'(ramREN), 32'd1);
        check("s1_addr", ramaddr, 32'h100);
        check("s1_dwait", 32'(dwait), 32'd2);
        tick();
        dc_addr[0] = 32'h104;
        @(negedge CLK);
        tick();
        dc_ren[0] = 1'b0;
        drained("s1_drained");

        // 2: data beats instruction in the same cycle
        expect_dburst(1, 1'b0, 32'h400, 32'h0);
        expect_beat(1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 2'b11);
        fork
            dcache_burst(1, 1'b0, 32'h400, 32'h0, 0);
            icache_fetch(0, 32'h300);
        join
        drained("s2_drained");

        // 3: write burst with a one-cycle gap keeps the lock against icache1
        expect_dburst(0, 1'b1, 32'h200, 32'hA0);
        expect_beat(1'b1, 1'b0, 32'h500, 32'h0, 2'b01, 2'b11);
        fork
            dcache_burst(0, 1'b1, 32'h200, 32'hA0, 1);
            begin
                repeat (2) tick();
                ic_ren[1] = 1'b1; ic_addr[1] = 32'h500;
                @(negedge CLK);
                check("s3_gap_iwait1", 32'(iwait[1]), 32'd1);
                check("s3_gap_wen", 32'(ramWEN), 32'd0);
                wait_low(1'b0, 1);
                tick();
                ic_ren[1] = 1'b0;
            end
        join
        drained("s3_drained");

        // 4: continuous dcache traffic alternates cores
        expect_dburst(0, 1'b0, 32'h600, 32'h0);
        expect_dburst(1, 1'b0, 32'h800, 32'h0);
        expect_dburst(0, 1'b0, 32'h700, 32'h0);
        expect_dburst(1, 1'b0, 32'h900, 32'h0);
        fork
            begin
                dcache_burst(0, 1'b0, 32'h600, 32'h0, 0);
                dcache_burst(0, 1'b0, 32'h700, 32'h0, 0);
            end
            begin
                dcache_burst(1, 1'b0, 32'h800, 32'h0, 0);
                dcache_burst(1, 1'b0, 32'h900, 32'h0, 0);
            end
        join
        drained("s4_drained");

        // idle timeout releases a dcache that stops after one word
        expect_beat(1'b1, 1'b0, 32'hB0, 32'h0, 2'b11, 2'b01);
        expect_beat(1'b1, 1'b0, 32'hC0, 32'h0, 2'b10, 2'b11);
        fork
            dcache_single(1, 32'hB0);
            begin
                tick();
                icache_fetch(0, 32'hC0);
            end
        join
        drained("s_idle_drained");

        // 5: read+write together, RAM not ready for three cycles
        ramstate = BUSY;
        dc_ren[0] = 1'b1; dc_wen[0] = 1'b1; dc_addr[0] = 32'h40; dc_store[0] = 32'h5555;
        @(negedge CLK);
        check("s5_idle_dwait", 32'(dwait), 32'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            ramstate = (k == 1) ? ERROR : BUSY;
            @(negedge CLK);
            check("s5_wen", 32'(ramWEN), 32'd1);
            check("s5_ren", 32'(ramREN), 32'd0);
            check("s5_busy_dwait", 32'(dwait[0]), 32'd1);
        end
        tick();
        ramstate = ACCESS;
        expect_beat(1'b0, 1'b1, 32'h40, 32'h5555, 2'b11, 2'b10);
        @(negedge CLK);
        check("s5_access_dwait", 32'(dwait[0]), 32'd0);
        tick();
        ramstate = BUSY; dc_addr[0] = 32'h44; dc_store[0] = 32'h5556;
        @(negedge CLK);
        check("s5_dwait_back", 32'(dwait[0]), 32'd1);
        tick();
        ramstate = ACCESS;
        expect_beat(1'b0, 1'b1, 32'h44, 32'h5556, 2'b11, 2'b10);
        @(negedge CLK);
        tick();
        dc_ren[0] = 1'b0; dc_wen[0] = 1'b0;
        @(negedge CLK);
        check("s5_release", 32'(ramWEN), 32'd0);
        drained("s5_drained");

        // 6: reset mid-burst drops strobes at once and clears rr/beats
        expect_beat(1'b1, 1'b0, 32'hA0, 32'h0, 2'b11, 2'b10);
        dc_ren[0] = 1'b1; dc_addr[0] = 32'hA0;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        tick();
        dc_addr[0] = 32'hA4;
        #1;
        check("s6_pre_ren", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        check("s6_async_ren", 32'(ramREN), 32'd0);
        check("s6_async_wen", 32'(ramWEN), 32'd0);
        check("s6_async_dwait", 32'(dwait), 32'd3);
        check("s6_async_addr", ramaddr, 32'd0);
        dc_ren[0] = 1'b0;
        tick();
        nRST = 1'b1;
        check("s6_pre_flush", 32'(sb.size()), 32'd0);
        expect_dburst(0, 1'b0, 32'hC00, 32'h0);
        expect_dburst(1, 1'b0, 32'hD00, 32'h0);
        fork
            dcache_burst(0, 1'b0, 32'hC00, 32'h0, 0);
            dcache_burst(1, 1'b0, 32'hD00, 32'h0, 0);
        join
        drained("s6_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
